pio_out_blink: RTL and testbench

//  Parametrised Avalon-MM slave output PIO. Next generation of the board LED/GPIO output port.

---
 rtl/pio_out_pkg.sv | 15 +
 rtl/pio_blink_prescaler.sv | 46 ++++
 rtl/pio_out_blink.sv | 104 ++++++++++
 tb/tb_pio_out_blink.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pio_out_pkg.sv
// Shared constants for the blinking output PIO: register word addresses
// and the width of the Avalon word address.
package pio_out_pkg;

  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_SET    = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_CLR    = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_TOGGLE = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_BLINK  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_OUT    = 3'd6;

endpackage

// File: rtl/pio_blink_prescaler.sv
// Blink prescaler: counts 0..period and flips the blink phase on each
// terminal count, so each phase lasts period+1 cycles. A zero period
// parks the phase high. A restart (PERIOD write) clears the count and
// starts a fresh "on" phase.
module pio_blink_prescaler #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] period,
  input  logic             restart,
  output logic             phase
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Next count/phase: restart and zero period both force the "on" phase.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart || (period == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and phase registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/pio_out_blink.sv
// Avalon-MM output PIO with atomic SET/CLR/TOGGLE writes and optional
// per-bit hardware blink. Zero wait states, combinational read.
// Build option: define PIO_OUT_BLINK_EN to include the BLINK/PERIOD
// registers and the prescaler; otherwise out_port simply mirrors DATA.
module pio_out_blink
  import pio_out_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q, data_d;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];

  // DATA next value: plain, set, clear and toggle writes.
  always_comb begin
    data_d = data_q;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_d = wd;
        ADDR_SET:    data_d = data_q | wd;
        ADDR_CLR:    data_d = data_q & ~wd;
        ADDR_TOGGLE: data_d = data_q ^ wd;
        default:     data_d = data_q;
      endcase
    end
  end

  // DATA register; reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) data_q <= RESET_VALUE;
    else       data_q <= data_d;
  end

`ifdef PIO_OUT_BLINK_EN
  logic [WIDTH-1:0] blink_q, blink_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             restart;
  logic             phase;

  assign restart = wr && (address == ADDR_PERIOD);

  // BLINK mask and PERIOD next values.
  always_comb begin
    blink_d  = blink_q;
    period_d = period_q;
    if (wr && (address == ADDR_BLINK))  blink_d  = wd;
    if (restart)                        period_d = writedata[CNT_W-1:0];
  end

  // BLINK and PERIOD registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q  <= '0;
      period_q <= '0;
    end else begin
      blink_q  <= blink_d;
      period_q <= period_d;
    end
  end

  pio_blink_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .period  (period_q),
    .restart (restart),
    .phase   (phase)
  );

  // Blinking bits are masked off during the "off" phase.
  assign out_port = data_q & ~(blink_q & {WIDTH{~phase}});
`else
  assign out_port = data_q;
`endif

  // Read mux, zero-extended; write-only and unused addresses read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0] = data_q;
`ifdef PIO_OUT_BLINK_EN
      ADDR_BLINK:  readdata[WIDTH-1:0] = blink_q;
      ADDR_PERIOD: readdata[CNT_W-1:0] = period_q;
`endif
      ADDR_OUT:    readdata[WIDTH-1:0] = out_port;
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pio_out_blink.sv
// Self-checking bench for pio_out_blink: directed scenarios with literal
// expectations, then randomized bus traffic compared every cycle against
// a behavioural model (phase derived from elapsed cycles since restart).
module tb_pio_out_blink;
  localparam int          WIDTH = 10;
  localparam int          CNT_W = 24;
  localparam logic [9:0]  RV    = 10'h155;
  localparam logic [9:0]  M     = 10'h3FF;
  localparam logic [23:0] PM    = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [9:0]  out_port;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  // Model state
  logic [9:0]  m_data = RV;
  logic [9:0]  m_blink = '0;
  logic [23:0] m_period = '0;
  longint      m_t = 0;

  pio_out_blink #(.WIDTH(WIDTH), .RESET_VALUE(RV), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] model_out();
    logic ph;
`ifdef PIO_OUT_BLINK_EN
    if (m_period == 0) ph = 1'b1;
    else               ph = ((m_t / (longint'(m_period) + 1)) % 2) == 0;
    return m_data & ~(m_blink & (ph ? 10'h000 : M));
`else
    ph = 1'b1;
    return m_data & {WIDTH{ph}};
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {22'd0, m_data};
`ifdef PIO_OUT_BLINK_EN
      3'd4: return {22'd0, m_blink};
      3'd5: return {8'd0, m_period};
`endif
      3'd6: return {22'd0, model_out()};
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive, clock, advance the model, settle.
  task automatic cyc(input bit rst, input bit cs, input bit wn,
                     input logic [2:0] a, input logic [31:0] w);
    reset = rst; chipselect = cs; write_n = wn; address = a; writedata = w;
    @(posedge clk);
    if (rst) begin
      m_data = RV; m_blink = '0; m_period = '0; m_t = 0;
    end else begin
      m_t++;
      if (cs && !wn) begin
        case (a)
          3'd0: m_data = w[9:0];
          3'd1: m_data = m_data | w[9:0];
          3'd2: m_data = m_data & ~w[9:0];
          3'd3: m_data = m_data ^ w[9:0];
`ifdef PIO_OUT_BLINK_EN
          3'd4: m_blink = w[9:0];
          3'd5: begin m_period = w[23:0] & PM; m_t = 0; end
`endif
          default: ;
        endcase
      end
    end
    $display("txn rst=%0b wr=%0b addr=%0d wd=%h -> model out=%h", rst, cs & ~wn, a, w, model_out());
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] w);
    cyc(0, 1, 0, a, w);
  endtask

  task automatic idle(input logic [2:0] a);
    cyc(0, 0, 1, a, 32'd0);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("model_out_port", {22'd0, out_port}, {22'd0, model_out()});
      chk("model_readdata", readdata, model_read(address));
    end
  end

  initial begin
    logic [6:0] pat3;
    logic [5:0] pat4;
    pat3 = 7'b1111000;
    pat4 = 6'b110011;

    cyc(1, 0, 1, 3'd0, 0);
    cyc(1, 0, 1, 3'd0, 0);
    started = 1;

    // Reset state
    chk("reset_out", {22'd0, out_port}, 32'h155);
    idle(3'd0); chk("reset_rd_data", readdata, 32'h155);
    idle(3'd4); chk("reset_rd_blink", readdata, 32'h0);
    idle(3'd5); chk("reset_rd_period", readdata, 32'h0);

    // Atomic writes
    wr(3'd0, 32'h0F0);
    wr(3'd1, 32'h003);
    wr(3'd2, 32'h010);
    wr(3'd3, 32'h301);
    chk("atomic_out", {22'd0, out_port}, 32'h3E2);
    idle(3'd1); chk("rd_set", readdata, 32'h0);
    idle(3'd2); chk("rd_clr", readdata, 32'h0);
    idle(3'd3); chk("rd_toggle", readdata, 32'h0);
    idle(3'd6); chk("rd_out", readdata, 32'h3E2);

`ifdef PIO_OUT_BLINK_EN
    // Blink with PERIOD=3: 4 on, 4 off
    wr(3'd0, 32'h3FF);
    wr(3'd4, 32'h001);
    wr(3'd5, 32'h003);
    for (int i = 0; i < 7; i++) begin
      chk("blink_p3_out", {22'd0, out_port}, {22'd0, 9'h1FF, pat3[6-i]});
      chk("blink_p3_rd_out", readdata, {22'd0, 9'h1FF, pat3[6-i]});
      if (i < 6) idle(3'd6);
    end
    // Mid off-phase restart with PERIOD=1
    cyc(0, 1, 0, 3'd5, 32'h1);
    address = 3'd6;
    for (int i = 0; i < 6; i++) begin
      chk("blink_p1_out", {22'd0, out_port}, {22'd0, 9'h1FF, pat4[5-i]});
      idle(3'd6);
    end
    wr(3'd5, 32'h0);
    for (int i = 0; i < 10; i++) begin
      chk("blink_p0_steady", {22'd0, out_port}, 32'h3FF);
      idle(3'd6);
    end
    // Period register truncation
    wr(3'd5, 32'hFFFF_FFFF);
    idle(3'd5); chk("period_trunc", readdata, 32'h00FF_FFFF);
    // Reset beats a same-cycle write, blink state cleared
    wr(3'd4, 32'h3FF);
    wr(3'd5, 32'h2);
    repeat (4) idle(3'd0);
    cyc(1, 1, 0, 3'd0, 32'h2AA);
    chk("reset_write_out", {22'd0, out_port}, 32'h155);
    idle(3'd4); chk("reset_write_blink", readdata, 32'h0);
    idle(3'd5); chk("reset_write_period", readdata, 32'h0);
`else
    // No blink hardware: BLINK/PERIOD absent
    wr(3'd0, 32'h2AA);
    wr(3'd4, 32'h3FF);
    wr(3'd5, 32'h5);
    idle(3'd4); chk("noblink_rd_blink", readdata, 32'h0);
    idle(3'd5); chk("noblink_rd_period", readdata, 32'h0);
    for (int i = 0; i < 100; i++) begin
      chk("noblink_steady", {22'd0, out_port}, 32'h2AA);
      idle(3'd6);
    end
    cyc(1, 1, 0, 3'd0, 32'h2AA);
    chk("reset_write_out", {22'd0, out_port}, 32'h155);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  a;
      logic [31:0] w;
      bit          rst;
      a = 3'($urandom_range(0, 7));
      w = $urandom;
      if (a == 3'd5 && $urandom_range(0, 15) != 0) w = $urandom_range(0, 6);
      rst = ($urandom_range(0, 299) == 0);
      cyc(rst, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a, w);
    end

    started = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
